if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage. It is the consumer of the EX-stage redirect interface (pc_branch / branch_addr / discard).
- Holds the PC and reads each 32-bit instruction as four byte reads over the arbitrated 8-bit memory bus.
- Presents {inst, pc, link_pc} to the IF/ID boundary with a valid/stall handshake.
- An EX redirect aborts any in-flight fetch and restarts at the branch target.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- stall_i  in  1  downstream (ID) cannot accept this cycle.
- pc_branch_i  in  1  redirect request from EX.
- branch_addr_i  in  32  redirect target.
- mem_gnt_i  in  1  arbiter grants the byte bus this cycle.
- mem_data_i  in  8  read byte; valid the cycle after a granted request.
- mem_req_o  out  1  byte-read request.
- mem_addr_o  out  32  byte address of the current request.
- inst_valid_o  out  1  inst_o/pc_o/link_pc_o hold a complete instruction.
- inst_o  out  32  assembled instruction, little-endian.
- pc_o  out  32  address of inst_o.
- link_pc_o  out  32  pc_o+4, mod 2^32; EX uses this as link_pc.

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC, state FETCH, req_idx=0, rsp_cnt=0, pending=0.
  - mem_req_o=0, inst_valid_o=0, inst_o=0, pc_o=0, link_pc_o=0.
  - Takes effect immediately, mid-fetch included; any outstanding byte is lost.
- States:
  - FETCH: issue and collect bytes.
  - HOLD: instruction presented, waiting for the transfer.
- Request side, FETCH only:
  - mem_req_o = (req_idx<4) && !pc_branch_i, combinational. mem_addr_o = pc + req_idx.
  - A request is accepted at an edge where mem_req_o && mem_gnt_i: req_idx++ and pending<=1 (slot = req_idx); otherwise pending<=0.
  - mem_gnt_i is ignored when mem_req_o=0.
- Response side:
  - If pending, mem_data_i is written to byte lane [slot] of the buffer: byte 0 = bits 7:0 … byte 3 = bits 31:24. Then rsp_cnt++.
  - When the 4th byte is captured: inst_o<=buffer incl. this byte, pc_o<=pc, link_pc_o<=pc+4, inst_valid_o<=1, state<=HOLD.
- Latency: with continuous grant, requests go out in cycles 0–3, data arrives in cycles 1–4, and inst_valid_o=1 from cycle 5.
- HOLD:
  - mem_req_o=0. Outputs are stable while stall_i=1.
  - Transfer happens at an edge with inst_valid_o && !stall_i && !pc_branch_i: inst_valid_o<=0, pc<=pc+4 (wraps), req_idx=rsp_cnt=0, state<=FETCH.
- Redirect, highest priority below reset (edge with pc_branch_i=1, any state):
  - pc<=branch_addr_i; req_idx, rsp_cnt, pending <=0; inst_valid_o<=0; state<=FETCH.
  - The byte in flight in the next cycle is dropped.
  - A held instruction is discarded even if stall_i=1. Redirect wins over a simultaneous transfer.
- No alignment requirement on branch_addr_i: fetching is byte-wise, so any address is fetched as given.
- The memory bus is read-only from this block; no write enable is driven.

Test Plan:
- Default reset, gnt=1, mem[0..3]=13,05,10,00 → mem_addr_o 0,1,2,3 in cycles 0–3; cycle 5 inst_valid_o=1, inst_o=32'h00100513, pc_o=0, link_pc_o=4.
- Same, then stall_i=1 for 3 cycles → inst_o/pc_o stable, mem_req_o=0. Release → next mem_addr_o=4 the cycle after the transfer.
- gnt alternating 1,0,1,0… → address advances only on granted cycles; same inst_o; inst_valid_o rises in cycle 8.
- pc_branch_i=1, branch_addr_i=32'h100 after 2 bytes captured → 3rd byte dropped; next mem_addr_o=0x100..0x103; pc_o=0x100, link_pc_o=0x104.
- Redirect in the same cycle as inst_valid_o=1, stall_i=0 → no transfer occurs, inst_valid_o=0 next cycle, fetch restarts at the target.
- RESET_PC=32'hFFFF_FFFC → link_pc_o=0, next fetch at 0. rst=0 asserted mid-fetch → all outputs 0 without waiting for clk.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: builds each 32-bit instruction from four byte reads on the
// arbitrated byte bus and hands it to ID with a valid/stall handshake; EX redirects restart fetch.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        pc_branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_data_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] link_pc_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  localparam logic [CNT_W-1:0] NBYTES     = CNT_W'(4);
  localparam logic [CNT_W-1:0] LAST_BYTE  = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [XLEN-1:0]  INST_BYTES = XLEN'(4);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]       state_q,   state_d;
  logic [XLEN-1:0]  pc_q,      pc_d;
  logic [CNT_W-1:0] req_idx_q, req_idx_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic             pending_q, pending_d;
  logic [1:0]       slot_q,    slot_d;
  logic [XLEN-1:0]  buf_q,     buf_d;
  logic             valid_q,   valid_d;
  logic [XLEN-1:0]  inst_q,    inst_d;
  logic [XLEN-1:0]  pc_out_q,  pc_out_d;
  logic [XLEN-1:0]  link_q,    link_d;

  logic             req_c;
  logic             accept_c;
  logic [XLEN-1:0]  buf_wr_c;

  // Request is suppressed during reset and in the redirect cycle itself.
  assign req_c      = rst && (state_q == S_FETCH) && (req_idx_q < NBYTES) && !pc_branch_i;
  assign accept_c   = req_c && mem_gnt_i;
  assign mem_req_o  = req_c;
  assign mem_addr_o = pc_q + XLEN'(req_idx_q);

  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_out_q;
  assign link_pc_o    = link_q;

  // Buffer with the returning byte merged into its little-endian lane.
  always_comb begin : buf_lane
    buf_wr_c = buf_q;
    case (slot_q)
      2'd0:    buf_wr_c[7:0]   = mem_data_i;
      2'd1:    buf_wr_c[15:8]  = mem_data_i;
      2'd2:    buf_wr_c[23:16] = mem_data_i;
      default: buf_wr_c[31:24] = mem_data_i;
    endcase
  end

  always_comb begin : next_state
    state_d   = state_q;
    pc_d      = pc_q;
    req_idx_d = req_idx_q;
    rsp_cnt_d = rsp_cnt_q;
    pending_d = 1'b0;
    slot_d    = slot_q;
    buf_d     = buf_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    pc_out_d  = pc_out_q;
    link_d    = link_q;

    if (pc_branch_i) begin
      pc_d      = branch_addr_i;
      req_idx_d = '0;
      rsp_cnt_d = '0;
      valid_d   = 1'b0;
      state_d   = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (accept_c) begin
            req_idx_d = req_idx_q + CNT_ONE;
            pending_d = 1'b1;
            slot_d    = req_idx_q[1:0];
          end
          if (pending_q) begin
            buf_d     = buf_wr_c;
            rsp_cnt_d = rsp_cnt_q + CNT_ONE;
            if (rsp_cnt_q == LAST_BYTE) begin
              inst_d   = buf_wr_c;
              pc_out_d = pc_q;
              link_d   = pc_q + INST_BYTES;
              valid_d  = 1'b1;
              state_d  = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (valid_q && !stall_i) begin
            valid_d   = 1'b0;
            pc_d      = pc_q + INST_BYTES;
            req_idx_d = '0;
            rsp_cnt_d = '0;
            state_d   = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      req_idx_q <= '0;
      rsp_cnt_q <= '0;
      pending_q <= 1'b0;
      slot_q    <= '0;
      buf_q     <= '0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      pc_out_q  <= '0;
      link_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_idx_q <= req_idx_d;
      rsp_cnt_q <= rsp_cnt_d;
      pending_q <= pending_d;
      slot_q    <= slot_d;
      buf_q     <= buf_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      pc_out_q  <= pc_out_d;
      link_q    <= link_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: word-level reference model checked every cycle, plus literal pins
// for the directed scenarios (latency, stall, gnt gaps, redirects, PC wrap, async reset).
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, pc_branch_i, mem_gnt_i;
  logic [31:0] branch_addr_i;
  logic [7:0]  mem_data_i;

  logic        mem_req_o, inst_valid_o;
  logic [31:0] mem_addr_o, inst_o, pc_o, link_pc_o;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_inst, w_pc, w_link;

  int checks = 0;
  int failures = 0;

  // Reference model state: transaction-level view of the fetch in progress.
  logic [31:0] m_pc;
  int          m_iss, m_rcv;
  logic        m_fly, m_hold;
  logic [31:0] m_fly_addr;

  logic        obs_req, obs_valid, obs2_req;
  logic [31:0] obs_addr, obs_inst, obs_pc, obs_link, obs2_addr, obs2_pc, obs2_link;

  always #5 clk = ~clk;

  if_fetch u_dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .pc_branch_i(pc_branch_i),
    .branch_addr_i(branch_addr_i), .mem_gnt_i(mem_gnt_i), .mem_data_i(mem_data_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .pc_o(pc_o), .link_pc_o(link_pc_o)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall_i(stall_i), .pc_branch_i(pc_branch_i),
    .branch_addr_i(branch_addr_i), .mem_gnt_i(mem_gnt_i), .mem_data_i(mem_data_i),
    .mem_req_o(w_req), .mem_addr_o(w_addr), .inst_valid_o(w_valid),
    .inst_o(w_inst), .pc_o(w_pc), .link_pc_o(w_link)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h13;
      32'h1:   return 8'h05;
      32'h2:   return 8'h10;
      32'h3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_iss = 0; m_rcv = 0; m_fly = 1'b0; m_hold = 1'b0; m_fly_addr = 32'h0;
  endtask

  // One clock cycle: drive inputs at the negedge, compare at +1, advance the model, move to next negedge.
  task automatic do_cycle(input logic st, input logic br, input logic [31:0] ba, input logic gnt);
    logic        exp_req, new_fly;
    logic [31:0] exp_addr;
    stall_i = st; pc_branch_i = br; branch_addr_i = ba; mem_gnt_i = gnt;
    mem_data_i = m_fly ? mem_byte(m_fly_addr) : 8'($urandom);
    #1;
    exp_req  = !m_hold && (m_iss < 4) && !br;
    exp_addr = m_pc + 32'(m_iss);
    obs_req = mem_req_o; obs_addr = mem_addr_o; obs_valid = inst_valid_o;
    obs_inst = inst_o; obs_pc = pc_o; obs_link = link_pc_o;
    obs2_req = w_req; obs2_addr = w_addr; obs2_pc = w_pc; obs2_link = w_link;
    chk("mem_req", 32'(mem_req_o), 32'(exp_req));
    if (exp_req) chk("mem_addr", mem_addr_o, exp_addr);
    chk("inst_valid", 32'(inst_valid_o), 32'(m_hold));
    if (m_hold) begin
      chk("inst", inst_o, mem_word(m_pc));
      chk("pc", pc_o, m_pc);
      chk("link_pc", link_pc_o, m_pc + 32'd4);
    end
    new_fly = exp_req && gnt;
    if (br) begin
      m_pc = ba; m_iss = 0; m_rcv = 0; m_fly = 1'b0; m_hold = 1'b0;
    end else if (m_hold) begin
      if (!st) begin
        m_hold = 1'b0; m_pc = m_pc + 32'd4; m_iss = 0; m_rcv = 0;
      end
      m_fly = 1'b0;
    end else begin
      if (m_fly) begin
        m_rcv++;
        if (m_rcv == 4) m_hold = 1'b1;
      end
      if (new_fly) begin
        m_fly_addr = exp_addr;
        m_iss++;
      end
      m_fly = new_fly;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},   32'(mem_req_o),    32'h0);
    chk({tag, "_valid"}, 32'(inst_valid_o), 32'h0);
    chk({tag, "_inst"},  inst_o,    32'h0);
    chk({tag, "_pc"},    pc_o,      32'h0);
    chk({tag, "_link"},  link_pc_o, 32'h0);
    chk({tag, "_w_req"},   32'(w_req),   32'h0);
    chk({tag, "_w_valid"}, 32'(w_valid), 32'h0);
    chk({tag, "_w_inst"},  w_inst, 32'h0);
    chk({tag, "_w_pc"},    w_pc,   32'h0);
    chk({tag, "_w_link"},  w_link, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall_i = 1'b0; pc_branch_i = 1'b0; branch_addr_i = 32'h0;
    mem_gnt_i = 1'b0; mem_data_i = 8'h0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_zero("rst");
    rst = 1'b1;

    // Continuous grant: four requests then a valid word in cycle 5.
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (k < 4) chk("t1_addr", obs_addr, 32'(k));
      if (k == 0) chk("t1_w_addr", obs2_addr, 32'hFFFF_FFFC);
    end
    // Stall for three cycles: outputs frozen, no requests.
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b1, 1'b0, 32'h0, 1'b1);
      chk("t2_valid", 32'(obs_valid), 32'h1);
      chk("t2_inst", obs_inst, 32'h0010_0513);
      chk("t2_pc", obs_pc, 32'h0);
      chk("t2_link", obs_link, 32'h4);
      chk("t2_req", 32'(obs_req), 32'h0);
      if (k == 0) begin
        chk("t2_w_pc", obs2_pc, 32'hFFFF_FFFC);
        chk("t2_w_link", obs2_link, 32'h0);
      end
    end
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t2_next_addr", obs_addr, 32'h4);
    chk("t2_next_req", 32'(obs_req), 32'h1);
    chk("t2_w_next_addr", obs2_addr, 32'h0);

    // Alternating grant after a redirect back to 0.
    do_cycle(1'b0, 1'b1, 32'h0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      do_cycle(1'b0, 1'b0, 32'h0, (k % 2) == 0);
      if (k == 7) chk("t3_valid_c7", 32'(obs_valid), 32'h0);
      if (k == 8) begin
        chk("t3_valid_c8", 32'(obs_valid), 32'h1);
        chk("t3_inst", obs_inst, 32'h0010_0513);
      end
    end

    // Redirect to 0x100 after two bytes of the word at 4 have been captured.
    for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    do_cycle(1'b0, 1'b1, 32'h100, 1'b1);
    chk("t4_req_in_redirect", 32'(obs_req), 32'h0);
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (k < 4) chk("t4_addr", obs_addr, 32'h100 + 32'(k));
    end

    // Redirect coincident with a transferable instruction: no transfer.
    do_cycle(1'b0, 1'b1, 32'h200, 1'b1);
    chk("t4_valid", 32'(obs_valid), 32'h1);
    chk("t4_inst", obs_inst, 32'hA7A6_A5A4);
    chk("t4_pc", obs_pc, 32'h100);
    chk("t4_link", obs_link, 32'h104);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t5_valid_drop", 32'(obs_valid), 32'h0);
    chk("t5_addr", obs_addr, 32'h200);
    for (int k = 0; k < 4; k++) do_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect while stalled discards the held word; then fetch across the top of memory.
    do_cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk("t5_pc", obs_pc, 32'h200);
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 3) chk("t6_addr_top", obs_addr, 32'hFFFF_FFFF);
    end
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_link_wrap", obs_link, 32'h0);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t6_wrap_addr", obs_addr, 32'h0);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset asserted mid-fetch, away from any clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk_zero("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Mixed traffic with random grants, stalls and redirects.
    for (int k = 0; k < 200; k++) begin
      do_cycle(($urandom % 3) == 0, ($urandom % 16) == 0, $urandom, ($urandom % 4) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
